// File: rtl/fifo_param_if.sv
// Producer/consumer-side bundle for fifo_param: flush and the write and read
// requests in, show-ahead data, status flags and occupancy out.
interface fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             CLEAR_N;
    logic             WRITE;
    logic             READ;
    logic [WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0] DATA_OUT;
    logic             F_FULL_N;
    logic             F_EMPTY_N;
    logic             F_AFULL_N;
    logic             F_AEMPTY_N;
    logic             OVERFLOW;
    logic             UNDERFLOW;
    logic [CW-1:0]    USE_DW;

    // User side: issues requests and observes the FIFO state
    modport master (
        output CLEAR_N, WRITE, READ, DATA_IN,
        input  DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N,
               OVERFLOW, UNDERFLOW, USE_DW
    );

    // FIFO side
    modport slave (
        input  CLEAR_N, WRITE, READ, DATA_IN,
        output DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N,
               OVERFLOW, UNDERFLOW, USE_DW
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous show-ahead FIFO with almost-full/almost-empty
// flags, sticky overflow/underflow flags and a full-range occupancy count.
module fifo_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int AFULL_LVL  = DEPTH - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic         CLOCK,
    input  logic         RESET,
    fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          rd_acc, wr_acc, mem_we;

    // Accept decisions and next-state; reset and flush override any request
    // in the same cycle, so neither the array nor the error flags see it.
    always_comb begin
        rd_acc   = bus.READ && (count_q != '0);
        wr_acc   = bus.WRITE && ((count_q != DEPTH_C) || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        mem_we   = 1'b0;
        if (RESET || !bus.CLEAR_N) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            mem_we = wr_acc;
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
            if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
            if (bus.WRITE && !wr_acc) ovf_d = 1'b1;
            if (bus.READ && !rd_acc)  udf_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge CLOCK) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
    end

    // Storage array; contents deliberately survive reset and flush
    always_ff @(posedge CLOCK) begin
        if (mem_we) mem[wr_ptr_q] <= bus.DATA_IN;
    end

    // Show-ahead head word and flags decoded from registered state only
    assign bus.DATA_OUT   = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign bus.F_FULL_N   = (count_q != DEPTH_C);
    assign bus.F_EMPTY_N  = (count_q != '0);
    assign bus.F_AFULL_N  = (count_q < AFULL_C);
    assign bus.F_AEMPTY_N = (count_q > AEMPTY_C);
    assign bus.OVERFLOW   = ovf_q;
    assign bus.UNDERFLOW  = udf_q;
    assign bus.USE_DW     = count_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (8 x 32, AFULL 28, AEMPTY 4). Stimulus pushes
// each word it expects the FIFO to accept into a scoreboard queue; a monitor
// pops and compares the head word whenever an accepted read is presented.
module tb_fifo_param;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] sb_q [$];

    fifo_param_if #(.WIDTH(8), .DEPTH(32)) bus ();

    fifo_param #(.WIDTH(8), .DEPTH(32), .AFULL_LVL(28), .AEMPTY_LVL(4)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; inputs return to idle just after the edge
    task automatic cycle(input bit w, input bit r, input logic [7:0] d,
                         input bit push, input bit rs, input bit cl);
        bus.WRITE   = w;
        bus.READ    = r;
        bus.DATA_IN = d;
        rst         = rs;
        bus.CLEAR_N = ~cl;
        @(posedge clk);
        #1;
        if (rs || cl) sb_q.delete();
        else if (push) sb_q.push_back(d);
        bus.WRITE   = 1'b0;
        bus.READ    = 1'b0;
        bus.DATA_IN = '0;
        rst         = 1'b0;
        bus.CLEAR_N = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " USE_DW"},     int'(bus.USE_DW), 0);
        check({tag, " F_EMPTY_N"},  int'(bus.F_EMPTY_N), 0);
        check({tag, " F_FULL_N"},   int'(bus.F_FULL_N), 1);
        check({tag, " F_AEMPTY_N"}, int'(bus.F_AEMPTY_N), 0);
        check({tag, " F_AFULL_N"},  int'(bus.F_AFULL_N), 1);
        check({tag, " OVERFLOW"},   int'(bus.OVERFLOW), 0);
        check({tag, " UNDERFLOW"},  int'(bus.UNDERFLOW), 0);
        check({tag, " DATA_OUT"},   int'(bus.DATA_OUT), 0);
    endtask

    // Monitor: on an accepted read the head word must match the scoreboard;
    // a read while the model is empty must show the empty head value
    initial begin
        forever begin
            @(negedge clk);
            if (bus.READ && !rst && bus.CLEAR_N) begin
                if (sb_q.size() > 0) begin
                    logic [7:0] exp_d;
                    exp_d = sb_q.pop_front();
                    check("read data", int'(bus.DATA_OUT), int'(exp_d));
                    $display("read  got %0d expected %0d", bus.DATA_OUT, exp_d);
                end else begin
                    check("empty read data", int'(bus.DATA_OUT), 0);
                end
            end
        end
    end

    initial begin
        bus.WRITE = 1'b0; bus.READ = 1'b0; bus.DATA_IN = '0;
        bus.CLEAR_N = 1'b1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // 1: reads on empty set UNDERFLOW; flush clears it
        cycle(0, 1, 8'd0, 0, 0, 0);
        cycle(0, 1, 8'd0, 0, 0, 0);
        check("s1 UNDERFLOW", int'(bus.UNDERFLOW), 1);
        check("s1 USE_DW", int'(bus.USE_DW), 0);
        check("s1 F_EMPTY_N", int'(bus.F_EMPTY_N), 0);
        check("s1 F_FULL_N", int'(bus.F_FULL_N), 1);
        cycle(0, 0, 8'd0, 0, 0, 1);
        check("s1 UNDERFLOW cleared", int'(bus.UNDERFLOW), 0);

        // 2: single word falls through, then read out
        cycle(1, 0, 8'd11, 1, 0, 0);
        check("s2 USE_DW", int'(bus.USE_DW), 1);
        check("s2 DATA_OUT", int'(bus.DATA_OUT), 11);
        check("s2 F_EMPTY_N", int'(bus.F_EMPTY_N), 1);
        cycle(0, 1, 8'd0, 0, 0, 0);
        check("s2 DATA_OUT after read", int'(bus.DATA_OUT), 0);
        check("s2 USE_DW after read", int'(bus.USE_DW), 0);
        check("s2 F_EMPTY_N after read", int'(bus.F_EMPTY_N), 0);

        // 3: fill, overflow, drain in order
        for (int i = 0; i < 32; i++) begin
            cycle(1, 0, 8'(i), 1, 0, 0);
            if (i == 26) check("s3 F_AFULL_N at 27", int'(bus.F_AFULL_N), 1);
            if (i == 27) check("s3 F_AFULL_N at 28", int'(bus.F_AFULL_N), 0);
            if (i == 30) check("s3 F_FULL_N at 31", int'(bus.F_FULL_N), 1);
        end
        check("s3 F_FULL_N", int'(bus.F_FULL_N), 0);
        check("s3 USE_DW full", int'(bus.USE_DW), 32);
        cycle(1, 0, 8'd99, 0, 0, 0);
        check("s3 OVERFLOW", int'(bus.OVERFLOW), 1);
        check("s3 USE_DW after overflow", int'(bus.USE_DW), 32);
        check("s3 head after overflow", int'(bus.DATA_OUT), 0);
        for (int i = 0; i < 32; i++) begin
            cycle(0, 1, 8'd0, 0, 0, 0);
            check("s3 drain USE_DW", int'(bus.USE_DW), 31 - i);
            check("s3 drain F_AEMPTY_N", int'(bus.F_AEMPTY_N), (31 - i <= 4) ? 0 : 1);
        end
        check("s3 F_EMPTY_N drained", int'(bus.F_EMPTY_N), 0);
        check("s3 OVERFLOW sticky", int'(bus.OVERFLOW), 1);
        cycle(0, 0, 8'd0, 0, 0, 1);

        // 4: read+write while full keeps count at DEPTH
        for (int i = 0; i < 32; i++) cycle(1, 0, 8'(100 + i), 1, 0, 0);
        cycle(1, 1, 8'd200, 1, 0, 0);
        check("s4 USE_DW", int'(bus.USE_DW), 32);
        check("s4 head advanced", int'(bus.DATA_OUT), 101);
        check("s4 OVERFLOW", int'(bus.OVERFLOW), 0);
        for (int i = 0; i < 31; i++) cycle(0, 1, 8'd0, 0, 0, 0);
        check("s4 last word", int'(bus.DATA_OUT), 200);
        cycle(0, 1, 8'd0, 0, 0, 0);
        check("s4 USE_DW drained", int'(bus.USE_DW), 0);

        // 5: read+write while empty: write wins, read flagged
        cycle(1, 1, 8'd5, 1, 0, 0);
        check("s5 USE_DW", int'(bus.USE_DW), 1);
        check("s5 DATA_OUT", int'(bus.DATA_OUT), 5);
        check("s5 UNDERFLOW", int'(bus.UNDERFLOW), 1);
        cycle(0, 1, 8'd0, 0, 0, 0);
        cycle(0, 0, 8'd0, 0, 0, 1);

        // 6: streaming across the pointer wrap, then reset mid-stream
        for (int i = 0; i < 20; i++) cycle(1, 0, 8'(i), 1, 0, 0);
        for (int j = 0; j < 50; j++) begin
            cycle(1, 1, 8'(20 + j), 1, 0, 0);
            check("s6 USE_DW steady", int'(bus.USE_DW), 20);
        end
        check("s6 head after stream", int'(bus.DATA_OUT), 50);
        check("s6 UNDERFLOW", int'(bus.UNDERFLOW), 0);
        cycle(1, 1, 8'hEE, 0, 1, 0);
        check_reset_state("s6 mid-stream reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
